// File: rtl/data_memory_multicycle.sv
// Word-addressed data memory with a fixed multi-cycle access latency.
// Each request is latched on acceptance and ready stays low until it completes.
module data_memory_multicycle #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RAM_DEPTH  = 16384,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  ready,
   output logic                  done
);
   localparam int IDX_W = $clog2(RAM_DEPTH);
   localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  op_wr_q, op_wr_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

   logic                  req;
   logic [IDX_W-1:0]      addr_idx;
   logic                  mem_we;
   logic                  addr_unused;

   // Byte offset and upper address bits are dropped so addresses alias modulo RAM_DEPTH.
   assign addr_idx    = addr[IDX_W+1:2];
   assign addr_unused = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};
   assign req         = rd_en | wr_en;
   assign rd_data     = rd_data_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_wr_d   = op_wr_q;
      idx_d     = idx_q;
      wdata_d   = wdata_q;
      rd_data_d = rd_data_q;
      ready     = 1'b1;
      done      = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready = ~req;
            if (req) begin
               // A simultaneous read and write is treated as a write.
               op_wr_d = wr_en;
               idx_d   = addr_idx;
               wdata_d = wr_data;
               if (LATENCY == 1) begin
                  state_d = S_DONE;
                  if (!wr_en) begin
                     rd_data_d = mem_q[addr_idx];
                  end
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_BUSY: begin
            ready = 1'b0;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               if (!op_wr_q) begin
                  rd_data_d = mem_q[idx_q];
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DONE: begin
            // The request still asserted here is the completing one; it is not re-accepted.
            done    = 1'b1;
            mem_we  = op_wr_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_data_q <= rd_data_d;
      end
   end

   always_ff @(posedge clk) begin
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
   end

   // Writes commit at the edge leaving DONE; reset on that edge discards the write.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[idx_q] <= wdata_q;
      end
   end
endmodule
